// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle: ID/EX hazard sources in, stall/flush controls out.
// The pipeline side uses the master modport, the hazard unit uses the slave modport.
interface hazard_unit_if #(
    parameter int REG_W = 3
);
    logic [REG_W-1:0] ID_rs1;
    logic [REG_W-1:0] ID_rs2;
    logic             ID_use_rs1;
    logic             ID_use_rs2;
    logic             ID_ret;
    logic             ID_pop;
    logic             EX_memread;
    logic             EX_regwrite;
    logic [REG_W-1:0] EX_rd;
    logic             EX_push;
    logic             EX_branch_taken;
    logic             hazard;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             ret_done;
    logic             busy;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_ret, ID_pop,
        output EX_memread, EX_regwrite, EX_rd, EX_push, EX_branch_taken,
        input  hazard, pc_write, ifid_write, ifid_flush, idex_flush, ret_done, busy
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_ret, ID_pop,
        input  EX_memread, EX_regwrite, EX_rd, EX_push, EX_branch_taken,
        output hazard, pc_write, ifid_write, ifid_flush, idex_flush, ret_done, busy
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the 19-bit CPU: load-use stalls, branch flushes, push->pop
// stalls and a RET_LAT-cycle PC hold after RET, all as combinational controls.
module hazard_unit #(
    parameter int REG_W   = 3,
    parameter int RET_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hu
);
    localparam int CNT_W = $clog2(RET_LAT) + 1;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        RET_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    logic [REG_W-1:0] id_rs1_s;
    logic [REG_W-1:0] id_rs2_s;
    logic [REG_W-1:0] ex_rd_s;
    logic             load_use_s;

    logic hazard_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic idex_flush_s;
    logic ret_done_s;
    logic busy_s;

    assign id_rs1_s = hu.ID_rs1;
    assign id_rs2_s = hu.ID_rs2;
    assign ex_rd_s  = hu.EX_rd;

    // Register 0 is an ordinary register here, so no zero-register exclusion.
    assign load_use_s = hu.EX_memread & hu.EX_regwrite &
                        ((hu.ID_use_rs1 & (ex_rd_s == id_rs1_s)) |
                         (hu.ID_use_rs2 & (ex_rd_s == id_rs2_s)));

    // State and RET-latency counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and hazard control decode; reset forces the free-running defaults.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        hazard_s     = 1'b0;
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        ret_done_s   = 1'b0;
        busy_s       = 1'b0;
        if (rst) begin
            state_next_s = RUN;
            cnt_next_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (hu.EX_branch_taken) begin
                        ifid_flush_s = 1'b1;
                        idex_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        hazard_s     = 1'b1;
                        pc_write_s   = 1'b0;
                        ifid_write_s = 1'b0;
                    end else if (hu.ID_ret) begin
                        // RET itself moves on to EX; only the fetch behind it is dropped.
                        pc_write_s   = 1'b0;
                        ifid_flush_s = 1'b1;
                        cnt_next_s   = CNT_W'(RET_LAT - 1);
                        state_next_s = RET_WAIT;
                    end else if (hu.ID_pop & hu.EX_push) begin
                        hazard_s     = 1'b1;
                        pc_write_s   = 1'b0;
                        ifid_write_s = 1'b0;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                RET_WAIT: begin
                    busy_s       = 1'b1;
                    hazard_s     = 1'b1;
                    pc_write_s   = 1'b0;
                    ifid_flush_s = 1'b1;
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_next_s = cnt_r - CNT_W'(1);
                    end else begin
                        pc_write_s   = 1'b1;
                        ret_done_s   = 1'b1;
                        state_next_s = RUN;
                    end
                end
                default: begin
                    state_next_s = RUN;
                    cnt_next_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign hu.hazard     = hazard_s;
    assign hu.pc_write   = pc_write_s;
    assign hu.ifid_write = ifid_write_s;
    assign hu.ifid_flush = ifid_flush_s;
    assign hu.idex_flush = idex_flush_s;
    assign hu.ret_done   = ret_done_s;
    assign hu.busy       = busy_s;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit; output vector order is
// {hazard, pc_write, ifid_write, ifid_flush, idex_flush, ret_done, busy}.
module tb_hazard_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_unit_if #(.REG_W(3)) hif ();

    hazard_unit #(.REG_W(3), .RET_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .hu  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] O_DEF    = 7'b0110000;
    localparam logic [6:0] O_STALL  = 7'b1000000;
    localparam logic [6:0] O_BRANCH = 7'b0111100;
    localparam logic [6:0] O_RET    = 7'b0011000;
    localparam logic [6:0] O_WAIT   = 7'b1011001;
    localparam logic [6:0] O_DONE   = 7'b1111011;

    function automatic logic [6:0] outs();
        return {hif.hazard, hif.pc_write, hif.ifid_write, hif.ifid_flush,
                hif.idex_flush, hif.ret_done, hif.busy};
    endfunction

    task automatic clear_inputs();
        hif.ID_rs1 = 3'd0; hif.ID_rs2 = 3'd0;
        hif.ID_use_rs1 = 1'b0; hif.ID_use_rs2 = 1'b0;
        hif.ID_ret = 1'b0; hif.ID_pop = 1'b0;
        hif.EX_memread = 1'b0; hif.EX_regwrite = 1'b0; hif.EX_rd = 3'd0;
        hif.EX_push = 1'b0; hif.EX_branch_taken = 1'b0;
    endtask

    task automatic set_load_use(input logic [2:0] rd);
        hif.EX_memread = 1'b1; hif.EX_regwrite = 1'b1; hif.EX_rd = rd;
        hif.ID_rs1 = rd; hif.ID_use_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        set_load_use(3'd3);
        hif.ID_ret = 1'b1;
        #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL reset_forced: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL reset_release: got %b expected %b", outs(), O_DEF);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk); set_load_use(3'd3); #1;
        checks++;
        if (outs() !== O_STALL) begin
            errors++; $display("FAIL load_use_rs1: got %b expected %b", outs(), O_STALL);
        end
        @(negedge clk); clear_inputs(); #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL load_use_clear: got %b expected %b", outs(), O_DEF);
        end
        // register 0 through rs2 must stall like any other register
        @(negedge clk);
        hif.EX_memread = 1'b1; hif.EX_regwrite = 1'b1; hif.EX_rd = 3'd0;
        hif.ID_rs1 = 3'd4; hif.ID_use_rs1 = 1'b1; hif.ID_rs2 = 3'd0; hif.ID_use_rs2 = 1'b1;
        #1;
        checks++;
        if (outs() !== O_STALL) begin
            errors++; $display("FAIL load_use_r0_rs2: got %b expected %b", outs(), O_STALL);
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_no_false_stall();
        @(negedge clk);
        hif.EX_memread = 1'b1; hif.EX_regwrite = 1'b1; hif.EX_rd = 3'd5;
        hif.ID_rs1 = 3'd5; hif.ID_use_rs1 = 1'b0;
        #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL no_stall_unused: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk);
        hif.ID_use_rs1 = 1'b1; hif.EX_regwrite = 1'b0;
        #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL no_stall_noregwr: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk);
        hif.EX_regwrite = 1'b1; hif.ID_rs1 = 3'd6;
        #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL no_stall_diffreg: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_priority();
        @(negedge clk);
        set_load_use(3'd3); hif.EX_branch_taken = 1'b1; hif.ID_ret = 1'b1;
        #1;
        checks++;
        if (outs() !== O_BRANCH) begin
            errors++; $display("FAIL prio_branch: got %b expected %b", outs(), O_BRANCH);
        end
        @(negedge clk); clear_inputs(); #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL prio_wrongpath_ret: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk);
        set_load_use(3'd2); hif.ID_ret = 1'b1; hif.ID_pop = 1'b1; hif.EX_push = 1'b1;
        #1;
        checks++;
        if (outs() !== O_STALL) begin
            errors++; $display("FAIL prio_loaduse_over_ret: got %b expected %b", outs(), O_STALL);
        end
        @(negedge clk); clear_inputs(); #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL prio_no_ret_entry: got %b expected %b", outs(), O_DEF);
        end
    endtask

    task automatic test_push_pop();
        @(negedge clk); hif.EX_push = 1'b1; hif.ID_pop = 1'b1; #1;
        checks++;
        if (outs() !== O_STALL) begin
            errors++; $display("FAIL push_pop_stall: got %b expected %b", outs(), O_STALL);
        end
        @(negedge clk); hif.EX_push = 1'b0; #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL push_pop_release: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk); clear_inputs();
    endtask

    // One RET: entry cycle, three RET_WAIT cycles, then RUN; load-use inputs
    // are applied during the wait and must be ignored.
    task automatic run_ret(input string tag);
        hif.ID_ret = 1'b1; #1;
        checks++;
        if (outs() !== O_RET) begin
            errors++; $display("FAIL %s_entry: got %b expected %b", tag, outs(), O_RET);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            if (i == 1) set_load_use(3'd1);
            #1;
            checks++;
            if (outs() !== ((i == 2) ? O_DONE : O_WAIT)) begin
                errors++;
                $display("FAIL %s_wait%0d: got %b expected %b", tag, i, outs(),
                         (i == 2) ? O_DONE : O_WAIT);
            end
        end
        clear_inputs();
    endtask

    task automatic test_ret();
        @(negedge clk); run_ret("ret");
        @(negedge clk); #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL ret_back_to_run: got %b expected %b", outs(), O_DEF);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); run_ret("b2b_first");
        @(negedge clk); run_ret("b2b_second");
        @(negedge clk); #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL b2b_run: got %b expected %b", outs(), O_DEF);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); hif.ID_ret = 1'b1;
        @(negedge clk); clear_inputs(); #1;
        checks++;
        if (outs() !== O_WAIT) begin
            errors++; $display("FAIL rstmid_busy1: got %b expected %b", outs(), O_WAIT);
        end
        @(negedge clk); #1;
        rst = 1'b1; #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL rstmid_async: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL rstmid_release: got %b expected %b", outs(), O_DEF);
        end
        @(negedge clk); #1;
        checks++;
        if (outs() !== O_DEF) begin
            errors++; $display("FAIL rstmid_no_done: got %b expected %b", outs(), O_DEF);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_priority();
        test_push_pop();
        test_ret();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
